cnt169_seq: RTL and testbench

- Sequencer for the sn74169 4-bit synchronous up/down counter.
- Accepts a job: preset, terminal value, direction, repeat count. Drives the counter's load, enable and direction pins, and watches its Q outputs.
- Counts from preset to terminal, optionally reloads and repeats, then signals completion.
- Sits between system control logic and one counter, so the counter's active-low pins are never hand-sequenced.

---
 rtl/cnt169_pkg.sv | 17 +
 rtl/cnt169_seq.sv | 149 ++++++++++++++
 tb/tb_cnt169_seq.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cnt169_pkg.sv
// Shared types and constants for the sn74169 counter sequencer.
package cnt169_pkg;

  localparam int CNT169_WIDTH   = 4;
  localparam int CNT169_LOOPS_W = 4;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/cnt169_seq.sv
// Job sequencer driving one sn74169 up/down counter (load, enables, direction).
// Optional step counter output STEPS is enabled by defining CNT169_STEPCOUNT_EN.
module cnt169_seq
  import cnt169_pkg::*;
#(
  parameter int WIDTH   = CNT169_WIDTH,
  parameter int LOOPS_W = CNT169_LOOPS_W
) (
  input  logic               CLK,
  input  logic               CLRB,
  input  logic               START,
  input  logic               STOP,
  input  logic               HOLD,
  input  logic [WIDTH-1:0]   PRESET,
  input  logic [WIDTH-1:0]   TERM,
  input  logic               DIR,
  input  logic [LOOPS_W-1:0] LOOPS,
  output logic               BUSY,
  output logic               DONE,
  output logic [WIDTH-1:0]   CNT_A,
  output logic               CNT_LOADB,
  output logic               CNT_ENPB,
  output logic               CNT_ENTB,
  output logic               CNT_UDB,
  input  logic [WIDTH-1:0]   CNT_Q
`ifdef CNT169_STEPCOUNT_EN
  ,
  output logic [WIDTH+LOOPS_W-1:0] STEPS
`endif
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     preset_q, preset_d;
  logic [WIDTH-1:0]     term_q, term_d;
  logic                 dir_q, dir_d;
  logic [LOOPS_W-1:0]   loops_q, loops_d;
  logic                 en_b_s;
  logic                 accept_s;
  logic                 at_term_s;

  // Next-state, job latching and the Mealy counter enable
  always_comb begin
    state_d  = state_q;
    preset_d = preset_q;
    term_d   = term_q;
    dir_d    = dir_q;
    loops_d  = loops_q;
    accept_s = 1'b0;

    at_term_s = (CNT_Q == term_q);
    en_b_s    = ~((state_q == ST_RUN) && !STOP && !HOLD && !at_term_s);

    case (state_q)
      ST_IDLE: begin
        if (START && !STOP) begin
          accept_s = 1'b1;
          preset_d = PRESET;
          term_d   = TERM;
          dir_d    = DIR;
          loops_d  = LOOPS;
          state_d  = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (STOP) begin
          state_d = ST_IDLE;
        end else if (HOLD) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (STOP) begin
          state_d = ST_IDLE;
        end else if (HOLD || !at_term_s) begin
          state_d = ST_RUN;
        end else if (loops_q == {LOOPS_W{1'b0}}) begin
          state_d = ST_DONE;
        end else begin
          // Another pass: reload the preset and burn one repeat
          loops_d = loops_q - {{(LOOPS_W-1){1'b0}}, 1'b1};
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched job registers
  always_ff @(posedge CLK) begin
    if (!CLRB) begin
      state_q  <= ST_IDLE;
      preset_q <= {WIDTH{1'b0}};
      term_q   <= {WIDTH{1'b0}};
      dir_q    <= CNT_UP;
      loops_q  <= {LOOPS_W{1'b0}};
    end else begin
      state_q  <= state_d;
      preset_q <= preset_d;
      term_q   <= term_d;
      dir_q    <= dir_d;
      loops_q  <= loops_d;
    end
  end

`ifdef CNT169_STEPCOUNT_EN
  logic [WIDTH+LOOPS_W-1:0] steps_q, steps_d;

  // Saturating count of edges on which the counter was enabled
  always_comb begin
    steps_d = steps_q;
    if (accept_s) begin
      steps_d = {(WIDTH+LOOPS_W){1'b0}};
    end else if (!en_b_s && (steps_q != {(WIDTH+LOOPS_W){1'b1}})) begin
      steps_d = steps_q + {{(WIDTH+LOOPS_W-1){1'b0}}, 1'b1};
    end else begin
      steps_d = steps_q;
    end
  end

  // Step counter register
  always_ff @(posedge CLK) begin
    if (!CLRB) begin
      steps_q <= {(WIDTH+LOOPS_W){1'b0}};
    end else begin
      steps_q <= steps_d;
    end
  end

  assign STEPS = steps_q;
`endif

  assign BUSY      = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign DONE      = (state_q == ST_DONE);
  assign CNT_LOADB = (state_q != ST_LOAD);
  assign CNT_A     = preset_q;
  assign CNT_UDB   = dir_q;
  assign CNT_ENPB  = en_b_s;
  assign CNT_ENTB  = en_b_s;

endmodule

// File: tb/tb_cnt169_seq.sv
// Scoreboard bench for cnt169_seq driving a behavioural sn74169 counter.
module tb_cnt169_seq;
  import cnt169_pkg::*;

  typedef struct packed {
    logic       loadb;
    logic       en;
    logic       busy;
    logic       done;
    logic [3:0] q;
    logic [3:0] a;
    logic       udb;
  } exp_t;

  logic       clk = 1'b0;
  logic       clrb, start, stop, hold, dir;
  logic [3:0] preset, term, loops;
  logic       busy, done, cnt_loadb, cnt_enpb, cnt_entb, cnt_udb;
  logic [3:0] cnt_a;
  logic [3:0] q_m = 4'd0;
`ifdef CNT169_STEPCOUNT_EN
  logic [7:0] steps;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  logic [3:0] q_prev = 4'd0;

  cnt169_seq dut (
    .CLK(clk), .CLRB(clrb), .START(start), .STOP(stop), .HOLD(hold),
    .PRESET(preset), .TERM(term), .DIR(dir), .LOOPS(loops),
    .BUSY(busy), .DONE(done), .CNT_A(cnt_a), .CNT_LOADB(cnt_loadb),
    .CNT_ENPB(cnt_enpb), .CNT_ENTB(cnt_entb), .CNT_UDB(cnt_udb), .CNT_Q(q_m)
`ifdef CNT169_STEPCOUNT_EN
    , .STEPS(steps)
`endif
  );

  always #5 clk = ~clk;

  // sn74169 behaviour: synchronous load, count when both enables low
  always @(posedge clk) begin
    if (cnt_loadb === 1'b0) q_m <= cnt_a;
    else if (cnt_enpb === 1'b0 && cnt_entb === 1'b0) q_m <= cnt_udb ? q_m + 4'd1 : q_m - 4'd1;
  end

  function automatic exp_t mk(input logic lb, input logic en, input logic bz, input logic dn,
                              input logic [3:0] q, input logic [3:0] a, input logic u);
    exp_t e;
    e.loadb = lb; e.en = en; e.busy = bz; e.done = dn; e.q = q; e.a = a; e.udb = u;
    return e;
  endfunction

  // Expected trace from the pass-length formula: LOAD, steps+1 RUN cycles, per pass
  task automatic push_job(input logic [3:0] pre, input logic [3:0] trm, input logic d,
                          input logic [3:0] lps);
    logic [3:0] st;
    logic [3:0] qv;
    st = d ? (trm - pre) : (pre - trm);
    qv = q_prev;
    for (int p = 0; p <= int'(lps); p++) begin
      exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, qv, pre, d));
      qv = pre;
      for (int k = 0; k <= int'(st); k++) begin
        exp_q.push_back(mk(1'b1, (k < int'(st)) ? 1'b0 : 1'b1, 1'b1, 1'b0, qv, pre, d));
        if (k < int'(st)) qv = d ? qv + 4'd1 : qv - 4'd1;
      end
    end
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, qv, pre, d));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, qv, pre, d));
    q_prev = qv;
  endtask

  // START in cycle 0, then pop one expectation per cycle and compare
  task automatic run_job(input string nm, input logic [3:0] pre, input logic [3:0] trm,
                         input logic d, input logic [3:0] lps, input int hold_from,
                         input int hold_to, input int stop_at, input int clrb_at,
                         input logic noise);
    exp_t e;
    int   cyc;
    @(posedge clk); #1;
    preset = pre; term = trm; dir = d; loops = lps;
    start = 1'b1; stop = 1'b0; hold = 1'b0; clrb = 1'b1;
    @(posedge clk);
    cyc = 1;
    while (exp_q.size() > 0) begin
      #1;
      e     = exp_q.pop_front();
      hold  = (cyc >= hold_from) && (cyc <= hold_to);
      stop  = (cyc == stop_at);
      clrb  = (cyc != clrb_at);
      start = noise && (cyc >= 3) && (exp_q.size() > 0);
      if (noise) begin
        preset = 4'($urandom); term = 4'($urandom); dir = 1'($urandom); loops = 4'($urandom);
      end else begin
        start = 1'b0;
      end
      #1;
      n_tests++; if (cnt_loadb !== e.loadb) begin n_fail++; $display("FAIL %s c%0d loadb: got %b want %b", nm, cyc, cnt_loadb, e.loadb); end
      n_tests++; if (cnt_enpb !== e.en) begin n_fail++; $display("FAIL %s c%0d enpb: got %b want %b", nm, cyc, cnt_enpb, e.en); end
      n_tests++; if (cnt_entb !== e.en) begin n_fail++; $display("FAIL %s c%0d entb: got %b want %b", nm, cyc, cnt_entb, e.en); end
      n_tests++; if (busy !== e.busy) begin n_fail++; $display("FAIL %s c%0d busy: got %b want %b", nm, cyc, busy, e.busy); end
      n_tests++; if (done !== e.done) begin n_fail++; $display("FAIL %s c%0d done: got %b want %b", nm, cyc, done, e.done); end
      n_tests++; if (q_m !== e.q) begin n_fail++; $display("FAIL %s c%0d q: got %0d want %0d", nm, cyc, q_m, e.q); end
      n_tests++; if (cnt_a !== e.a) begin n_fail++; $display("FAIL %s c%0d cnt_a: got %0d want %0d", nm, cyc, cnt_a, e.a); end
      n_tests++; if (cnt_udb !== e.udb) begin n_fail++; $display("FAIL %s c%0d udb: got %b want %b", nm, cyc, cnt_udb, e.udb); end
      cyc++;
      @(posedge clk);
    end
    #1;
    start = 1'b0; stop = 1'b0; hold = 1'b0; clrb = 1'b1;
  endtask

  task automatic test_reset;
    clrb = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0;
    preset = 4'd0; term = 4'd0; dir = 1'b0; loops = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", done); end
    n_tests++; if (cnt_loadb !== 1'b1) begin n_fail++; $display("FAIL reset loadb: got %b want 1", cnt_loadb); end
    n_tests++; if (cnt_enpb !== 1'b1 || cnt_entb !== 1'b1) begin n_fail++; $display("FAIL reset enables: got %b%b want 11", cnt_enpb, cnt_entb); end
    n_tests++; if (cnt_a !== 4'd0) begin n_fail++; $display("FAIL reset cnt_a: got %0d want 0", cnt_a); end
    n_tests++; if (cnt_udb !== CNT_UP) begin n_fail++; $display("FAIL reset udb: got %b want 1", cnt_udb); end
`ifdef CNT169_STEPCOUNT_EN
    n_tests++; if (steps !== 8'd0) begin n_fail++; $display("FAIL reset steps: got %0d want 0", steps); end
`endif
    clrb = 1'b1;
  endtask

  task automatic test_up;
    push_job(4'd3, 4'd7, CNT_UP, 4'd0);
    run_job("up", 4'd3, 4'd7, CNT_UP, 4'd0, -1, -1, -1, -1, 1'b0);
`ifdef CNT169_STEPCOUNT_EN
    n_tests++; if (steps !== 8'd4) begin n_fail++; $display("FAIL up steps: got %0d want 4", steps); end
`endif
  endtask

  task automatic test_down_wrap;
    push_job(4'd2, 4'd14, CNT_DN, 4'd0);
    run_job("down_wrap", 4'd2, 4'd14, CNT_DN, 4'd0, -1, -1, -1, -1, 1'b0);
  endtask

  task automatic test_zero_step;
    push_job(4'd5, 4'd5, CNT_UP, 4'd0);
    run_job("zero", 4'd5, 4'd5, CNT_UP, 4'd0, -1, -1, -1, -1, 1'b0);
`ifdef CNT169_STEPCOUNT_EN
    n_tests++; if (steps !== 8'd0) begin n_fail++; $display("FAIL zero steps: got %0d want 0", steps); end
`endif
  endtask

  task automatic test_back_to_back_reload;
    push_job(4'd0, 4'd2, CNT_UP, 4'd2);
    run_job("reload", 4'd0, 4'd2, CNT_UP, 4'd2, -1, -1, -1, -1, 1'b1);
`ifdef CNT169_STEPCOUNT_EN
    n_tests++; if (steps !== 8'd6) begin n_fail++; $display("FAIL reload steps: got %0d want 6", steps); end
`endif
  endtask

  task automatic test_hold;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, q_prev, 4'd3, 1'b1));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 4'd3, 1'b1));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 4'd4, 4'd3, 1'b1));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd4, 4'd3, 1'b1));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 4'd3, 1'b1));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 4'd3, 1'b1));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 4'd7, 4'd3, 1'b1));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 4'd7, 4'd3, 1'b1));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 4'd3, 1'b1));
    q_prev = 4'd7;
    run_job("hold", 4'd3, 4'd7, CNT_UP, 4'd0, 3, 5, -1, -1, 1'b0);
  endtask

  task automatic test_stop;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, q_prev, 4'd3, 1'b1));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 4'd3, 1'b1));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd4, 4'd3, 1'b1));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 4'd3, 1'b1));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 4'd3, 1'b1));
    q_prev = 4'd5;
    run_job("stop", 4'd3, 4'd7, CNT_UP, 4'd0, -1, -1, 4, -1, 1'b0);
    // START together with STOP in IDLE must not launch a job
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    n_tests++; if (busy !== 1'b0 || cnt_loadb !== 1'b1) begin n_fail++; $display("FAIL start_with_stop: got busy=%b loadb=%b want 0/1", busy, cnt_loadb); end
  endtask

  task automatic test_reset_midrun;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, q_prev, 4'd9, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 4'd9, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd8, 4'd9, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd7, 4'd9, 1'b0));
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 4'd0, 1'b1));
    q_prev = 4'd6;
    run_job("reset_mid", 4'd9, 4'd3, CNT_DN, 4'd0, -1, -1, -1, 4, 1'b0);
`ifdef CNT169_STEPCOUNT_EN
    n_tests++; if (steps !== 8'd0) begin n_fail++; $display("FAIL reset_mid steps: got %0d want 0", steps); end
`endif
  endtask

  initial begin
    test_reset();
    test_up();
    test_down_wrap();
    test_zero_step();
    test_back_to_back_reload();
    test_hold();
    test_stop();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
